imem_fetch_ctrl: RTL and testbench

Fetch sequencer for the single-cycle MIPS core's instruction memory. Owns the PC, drives the address of the combinational-read instruction memory and registers the returned word into a one-entry output slot. Hands instructions to decode through a valid/ready handshake and supports redirect (branch/jump), stall and halt. Sits between the instruction memory and the decode/control stage.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/fetch_slot.sv | 62 ++++++
 rtl/imem_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Purpose: shared types and constants for the MIPS fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: fetch_state_t FSM encoding, word width, default PC step and
// reset PC, and a saturating-increment helper used by the perf counters.
package mips_pkg;

  localparam int              WORD_W           = 32;
  localparam int              PC_STEP_DEFAULT  = 4;
  localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (v == {WORD_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_slot.sv
// Purpose: one-entry registered output slot between imem and decode.
// Latency: a loaded word is presented on the cycle after load_en.
// Backpressure: holds its word while instr_ready is low; can_load = !valid || ready.
// Ports: clk/rst; load_en, flush, consume controls from the fetch FSM;
// load_instr/load_pc word to capture; instr_ready from decode;
// can_load, instr_out, pc_out, instr_valid towards decode and the FSM.
module fetch_slot import mips_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              flush,
  input  logic              consume,
  input  logic [WORD_W-1:0] load_instr,
  input  logic [WORD_W-1:0] load_pc,
  input  logic              instr_ready,
  output logic              can_load,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pc_out,
  output logic              instr_valid
);

  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              vld_q, vld_d;

  assign can_load = !vld_q || instr_ready;

  // Flush wins over everything: a redirect drops the word even if decode
  // is accepting it in the same cycle. consume only empties the slot when
  // no new word replaces it (drain / halt path).
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (load_en) begin
      instr_d = load_instr;
      pc_d    = load_pc;
      vld_d   = 1'b1;
    end else if (consume && vld_q && instr_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
    end
  end

  assign instr_out   = instr_q;
  assign pc_out      = pc_q;
  assign instr_valid = vld_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Purpose: fetch sequencer owning the PC; feeds decode through a one-entry slot.
// Latency: first instruction valid one cycle after entering FETCH; 1 instr/cycle.
// Backpressure: instr_ready low stalls the PC and holds the slot.
// Ports: clk, rst (async, active-high); start, halt_req, redirect_valid/pc
// control; imem_addr/imem_rdata to a combinational-read instruction memory;
// instr_out/pc_out/instr_valid/instr_ready to decode; busy, halted status.
// Optional IMEM_FETCH_PERF_EN adds saturating fetch_count and stall_count.
module imem_fetch_ctrl import mips_pkg::*; #(
  parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                IMEM_WORDS = 32,
  parameter int                PC_STEP    = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              halted
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [WORD_W-1:0] fetch_count,
  output logic [WORD_W-1:0] stall_count
`endif
);

  // Byte span of the instruction memory; all PC arithmetic wraps inside it.
  localparam logic [WORD_W-1:0] PC_SPAN = 32'(IMEM_WORDS * 4);
  localparam logic [WORD_W-1:0] STEP    = 32'(PC_STEP);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              slot_load, slot_flush, slot_consume, slot_can_load;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    slot_load    = 1'b0;
    slot_flush   = 1'b0;
    slot_consume = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = RESET_PC;
        end
      end
      FETCH: begin
        // halt beats redirect; a redirect arriving with halt is dropped.
        if (halt_req) begin
          state_d      = DRAIN;
          slot_consume = 1'b1;
        end else if (redirect_valid) begin
          pc_d       = (redirect_pc & ~32'h3) % PC_SPAN;
          slot_flush = 1'b1;
        end else if (slot_can_load) begin
          slot_load = 1'b1;
          pc_d      = (pc_q + STEP) % PC_SPAN;
        end
      end
      DRAIN: begin
        slot_consume = 1'b1;
        if (!instr_valid) state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_addr = pc_q;
  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign halted    = (state_q == HALT);

  fetch_slot u_slot (
    .clk         (clk),
    .rst         (rst),
    .load_en     (slot_load),
    .flush       (slot_flush),
    .consume     (slot_consume),
    .load_instr  (imem_rdata),
    .load_pc     (pc_q),
    .instr_ready (instr_ready),
    .can_load    (slot_can_load),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .instr_valid (instr_valid)
  );

`ifdef IMEM_FETCH_PERF_EN
  logic              start_acc;
  logic [WORD_W-1:0] fetch_count_q, fetch_count_d;
  logic [WORD_W-1:0] stall_count_q, stall_count_d;

  assign start_acc = start && ((state_q == IDLE) || (state_q == HALT));

  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (start_acc) begin
      fetch_count_d = '0;
      stall_count_d = '0;
    end else begin
      if (slot_load) fetch_count_d = sat_inc(fetch_count_q);
      if ((state_q == FETCH) && instr_valid && !instr_ready)
        stall_count_d = sat_inc(stall_count_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Purpose: self-checking bench for imem_fetch_ctrl against a cycle-level
// behavioural model of the fetch rules (IMEM_WORDS=32, RESET_PC=0).
// Optional IMEM_FETCH_PERF_EN also checks the perf counters.
module tb_imem_fetch_ctrl;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DRAIN = 2, S_HALT = 3;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, redirect_valid, instr_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr_out, pc_out;
  logic        instr_valid, busy, halted;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  assign imem_rdata = mem[imem_addr[6:2]];

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .busy           (busy),
    .halted         (halted)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  int          m_st;
  logic [31:0] m_pc, m_instr, m_pcout, m_fc, m_sc;
  logic        m_vld;

  function automatic logic [98:0] obs_vec();
    return {imem_addr, instr_out, pc_out, instr_valid, busy, halted};
  endfunction

  function automatic logic [98:0] exp_vec();
    return {m_pc, m_instr, m_pcout, m_vld,
            (m_st == S_FETCH) || (m_st == S_DRAIN), m_st == S_HALT};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_pc = 32'h0; m_instr = 32'h0; m_pcout = 32'h0;
    m_vld = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
  endtask

  // Advance one clock: model next state from current inputs, then commit.
  task automatic step();
    int          st_n;
    logic [31:0] pc_n, ins_n, pco_n, fc_n, sc_n;
    logic        vld_n;
    st_n = m_st; pc_n = m_pc; ins_n = m_instr; pco_n = m_pcout;
    vld_n = m_vld; fc_n = m_fc; sc_n = m_sc;
    if (m_st == S_FETCH && m_vld && !instr_ready && m_sc != 32'hFFFF_FFFF)
      sc_n = m_sc + 1;
    case (m_st)
      S_IDLE, S_HALT:
        if (start) begin
          st_n = S_FETCH; pc_n = 32'h0; fc_n = 0; sc_n = 0;
        end
      S_FETCH:
        if (halt_req) begin
          st_n = S_DRAIN;
          if (m_vld && instr_ready) vld_n = 1'b0;
        end else if (redirect_valid) begin
          pc_n  = (redirect_pc & ~32'd3) % 128;
          vld_n = 1'b0;
        end else if (!m_vld || instr_ready) begin
          ins_n = mem[m_pc[6:2]];
          pco_n = m_pc;
          vld_n = 1'b1;
          pc_n  = (m_pc + 4) % 128;
          if (m_fc != 32'hFFFF_FFFF) fc_n = m_fc + 1;
        end
      S_DRAIN:
        if (!m_vld) st_n = S_HALT;
        else if (instr_ready) vld_n = 1'b0;
      default: st_n = S_IDLE;
    endcase
    @(posedge clk);
    #1;
    m_st = st_n; m_pc = pc_n; m_instr = ins_n; m_pcout = pco_n;
    m_vld = vld_n; m_fc = fc_n; m_sc = sc_n;
  endtask

  task automatic do_reset();
    start = 0; halt_req = 0; redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
    rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 0;
  endtask

  task automatic begin_fetch();
    do_reset();
    instr_ready = 1;
    start = 1;
    step();
    start = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1;
    #2;
    n_vec++;
    if (obs_vec() !== 99'h0) begin
      n_bad++;
      $display("FAIL reset: got %h required %h", obs_vec(), 99'h0);
    end
`ifdef IMEM_FETCH_PERF_EN
    n_vec++;
    if ({fetch_count, stall_count} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_perf: got %h required 0", {fetch_count, stall_count});
    end
`endif
    rst = 0;
  endtask

  task automatic test_stream();
    begin_fetch();
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL stream_enter: got %h required %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if ({instr_out, pc_out, instr_valid} !== {32'(10 * (i + 1)), 32'(4 * i), 1'b1}) begin
        n_bad++;
        $display("FAIL stream_word%0d: got instr %0d pc %0d vld %b required %0d %0d 1",
                 i, instr_out, pc_out, instr_valid, 10 * (i + 1), 4 * i);
      end
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL stream_model%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    begin_fetch();
    step();
    instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({instr_out, pc_out, imem_addr, instr_valid} !== {32'd10, 32'd0, 32'd4, 1'b1}) begin
        n_bad++;
        $display("FAIL stall%0d: got instr %0d pc %0d addr %0d vld %b required 10 0 4 1",
                 i, instr_out, pc_out, imem_addr, instr_valid);
      end
    end
`ifdef IMEM_FETCH_PERF_EN
    n_vec++;
    if ({fetch_count, stall_count} !== {32'd1, 32'd3}) begin
      n_bad++;
      $display("FAIL stall_perf: got fetch %0d stall %0d required 1 3", fetch_count, stall_count);
    end
`endif
    instr_ready = 1;
    step();
    n_vec++;
    if (obs_vec() !== exp_vec() || instr_out !== 32'd20) begin
      n_bad++;
      $display("FAIL stall_resume: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_redirect_wrap();
    begin_fetch();
    repeat (3) step();
    n_vec++;
    if (pc_out !== 32'd8) begin
      n_bad++;
      $display("FAIL redir_pre: got pc_out %0d required 8", pc_out);
    end
    redirect_valid = 1; redirect_pc = 32'h0000_0013;
    step();
    redirect_valid = 0;
    n_vec++;
    if ({instr_valid, imem_addr} !== {1'b0, 32'd16}) begin
      n_bad++;
      $display("FAIL redir_flush: got vld %b addr %0d required 0 16", instr_valid, imem_addr);
    end
    step();
    n_vec++;
    if ({pc_out, instr_out, instr_valid} !== {32'd16, mem[4], 1'b1}) begin
      n_bad++;
      $display("FAIL redir_target: got pc %0d instr %h required 16 %h", pc_out, instr_out, mem[4]);
    end
    redirect_valid = 1; redirect_pc = 32'h0000_007C;
    step();
    redirect_valid = 0;
    step();
    step();
    n_vec++;
    if ({pc_out, instr_out} !== {32'd0, mem[0]}) begin
      n_bad++;
      $display("FAIL wrap: got pc_out %0d instr %h required 0 %h", pc_out, instr_out, mem[0]);
    end
    redirect_valid = 1; redirect_pc = 32'h1000_0086;
    step();
    redirect_valid = 0;
    n_vec++;
    if (imem_addr !== 32'd4 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL redir_range: got addr %0d required 4", imem_addr);
    end
  endtask

  task automatic test_halt();
    begin_fetch();
    step();
    instr_ready = 0; halt_req = 1;
    redirect_valid = 1; redirect_pc = 32'h40;
    step();
    redirect_valid = 0;
    n_vec++;
    if ({busy, halted, instr_valid, imem_addr, pc_out} !== {3'b101, 32'd4, 32'd0}) begin
      n_bad++;
      $display("FAIL halt_enter: got busy %b halted %b vld %b addr %0d pc %0d required 1 0 1 4 0",
               busy, halted, instr_valid, imem_addr, pc_out);
    end
    step();
    n_vec++;
    if ({busy, halted, instr_valid} !== 3'b101) begin
      n_bad++;
      $display("FAIL drain_hold: got busy %b halted %b vld %b required 1 0 1", busy, halted, instr_valid);
    end
    instr_ready = 1;
    step();
    n_vec++;
    if ({busy, halted, instr_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL drain_accept: got busy %b halted %b vld %b required 1 0 0", busy, halted, instr_valid);
    end
    step();
    n_vec++;
    if ({busy, halted, imem_addr} !== {2'b01, 32'd4}) begin
      n_bad++;
      $display("FAIL halted: got busy %b halted %b addr %0d required 0 1 4", busy, halted, imem_addr);
    end
    halt_req = 0; start = 1;
    step();
    start = 0;
    step();
    n_vec++;
    if ({pc_out, instr_out, instr_valid, busy} !== {32'd0, mem[0], 2'b11} || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL restart: got pc %0d instr %h required 0 %h", pc_out, instr_out, mem[0]);
    end
  endtask

  task automatic test_async_reset();
    begin_fetch();
    step();
    step();
    #3;
    rst = 1;
    #1;
    n_vec++;
    if (obs_vec() !== 99'h0) begin
      n_bad++;
      $display("FAIL async_reset: got %h required 0", obs_vec());
    end
    model_reset();
    #2;
    rst = 0;
    start = 1;
    step();
    start = 0;
    step();
    n_vec++;
    if ({pc_out, instr_out, instr_valid} !== {32'd0, mem[0], 1'b1}) begin
      n_bad++;
      $display("FAIL async_restart: got pc %0d instr %h required 0 %h", pc_out, instr_out, mem[0]);
    end
  endtask

  task automatic test_random();
    begin_fetch();
    for (int c = 0; c < 800; c++) begin
      instr_ready    = ($urandom_range(9) < 7);
      start          = ($urandom_range(19) == 0);
      halt_req       = ($urandom_range(39) == 0);
      redirect_valid = ($urandom_range(14) == 0);
      redirect_pc    = $urandom;
      step();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cyc%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
`ifdef IMEM_FETCH_PERF_EN
      n_vec++;
      if ({fetch_count, stall_count} !== {m_fc, m_sc}) begin
        n_bad++;
        $display("FAIL random_perf cyc%0d: got %0d/%0d required %0d/%0d",
                 c, fetch_count, stall_count, m_fc, m_sc);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'd10; mem[1] = 32'd20; mem[2] = 32'd30; mem[3] = 32'd40;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
